spi_master_core: RTL and testbench
==================================

Name: spi_master_core

Overview:
- Single-lane SPI master (mode 0) shared by the memory controller for SPI flash instruction fetch and SPI RAM data access.
- A 1-cycle start pulse launches one framed transaction:
  - 32-bit command/address phase: 8-bit opcode plus 24-bit address.
  - Optional data phase of 0–32 bits, either write (MOSI) or read (MISO).
- Chip-select routing to flash or RAM is done outside this block.
- Completion is signalled by a 1-cycle done pulse.

Parameters:
- CLK_DIV, default 2: number of clk cycles per SPI clock half-period. Must be ≥1. SPI clock frequency = clk / (2*CLK_DIV).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  1-cycle request pulse; sampled only when idle.
- write_enable  input  1  1 = data phase drives data_in; 0 = data phase reads MISO into data_out.
- cmd_addr  input  32  command/address word, shifted out MSB first (bits [31:24] opcode, [23:0] address).
- data_len  input  6  data-phase length in bits (0..32; values >32 treated as 32).
- data_in  input  32  write data, left-aligned; bit 31 is sent first.
- data_out  output  32  read data, right-aligned; last received bit is in bit 0, unused upper bits are 0.
- done  output  1  1-cycle completion pulse.
- spi_clk  output  1  SPI clock; idles low.
- spi_cs_n  output  1  active-low chip select; idles high.
- spi_mosi  output  1  master out.
- spi_miso  input  1  master in.

Behaviour:
- Reset (async, any time, including mid-transaction):
  - spi_cs_n=1, spi_clk=0, spi_mosi=0, done=0, data_out=0; FSM returns to IDLE.
- States: IDLE -> SHIFT -> IDLE.
- At the clk edge E0 where IDLE samples start=1:
  - Latch cmd_addr, data_in, data_len (clamped), and write_enable.
  - Set N = 32 + data_len.
  - Drive spi_cs_n=0 and spi_mosi=cmd_addr[31]; clear the receive shift register.
- start while in SHIFT is ignored; inputs are only sampled at E0.
- Bit timing (mode 0, CPOL=0, CPHA=0), for each bit k = 0..N-1:
  - spi_clk low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - Rising edge: sample spi_miso.
  - Falling edge: spi_mosi advances to bit k+1.
- MOSI bit order:
  - cmd_addr[31..0] first.
  - Then, if write_enable=1, data_in[31], data_in[30], … for data_len bits.
  - If write_enable=0, spi_mosi is driven 0 during the data phase.
- MISO capture:
  - Only bits sampled during the data phase are kept, shifted in left: rx <= {rx[30:0], miso}.
  - After data_len bits, the first received bit sits at bit data_len-1.
  - Bits sampled during the command phase are discarded.
- Completion at edge E0 + 2*N*CLK_DIV (spi_clk already low after the last falling edge):
  - spi_cs_n <= 1, spi_mosi <= 0, done <= 1 for exactly one cycle.
  - data_out <= rx, but only when write_enable=0; on writes data_out keeps its previous value.
  - FSM returns to IDLE.
- data_out holds until the next completed read or reset.
- A new start may be accepted on the cycle done is high (back-to-back transfers). CS then has at least 1 cycle high between frames.
- data_len=0: the frame is 32 bits (command/address only); done still pulses and data_out becomes 0 when write_enable=0.
- Latency: start-sampling edge to the done-setting edge is exactly 2*N*CLK_DIV cycles (CLK_DIV=2, N=64 → 256).

Test Plan:
- Reset mid-transfer: assert rst_n=0 during the command phase -> immediately spi_cs_n=1, spi_clk=0, done=0, data_out=0; next start runs normally.
- Word read: cmd_addr=0x03000100, data_len=32, write_enable=0, slave returns bytes 0x13,0x00,0x50,0x00 MSB-first -> MOSI shows 0x03000100 then 32 zeros; data_out=0x13005000; done pulses once, 256 cycles after start (CLK_DIV=2); CS low for the whole frame.
- Byte write: cmd_addr=0x02000010, data_in=0xA5000000, data_len=8, write_enable=1 -> MOSI shows 0x02000010 then 0xA5; 40 rising spi_clk edges; data_out unchanged; done pulse.
- Halfword read: data_len=16, slave sends 0xBEEF -> data_out=0x0000BEEF.
- data_len=0: write_enable=0 -> exactly 32 spi_clk pulses; done pulses; data_out=0.
- start ignored while busy, then back-to-back: pulse start again mid-frame -> no effect; start on the done cycle -> second frame begins with CS re-asserted after at least 1 cycle high.

Source files
------------

// File: rtl/spi_master_core.sv
// Single-lane mode-0 SPI master: one framed transfer of a 32-bit command/address
// word followed by an optional 0..32-bit write or read data phase.
module spi_master_core #(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        write_enable,
  input  logic [31:0] cmd_addr,
  input  logic [5:0]  data_len,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        done,
  output logic        spi_clk,
  output logic        spi_cs_n,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             phase_q, phase_d;   // 0: spi_clk low half, 1: high half
  logic [6:0]       bit_q, bit_d;
  logic [6:0]       n_q, n_d;
  logic [63:0]      tx_q, tx_d;
  logic [31:0]      rx_q, rx_d;
  logic [31:0]      dout_q, dout_d;
  logic             we_q, we_d;
  logic             sclk_q, sclk_d;
  logic             cs_n_q, cs_n_d;
  logic             mosi_q, mosi_d;
  logic             done_q, done_d;
  logic [5:0]       len_clamped;

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    phase_d     = phase_q;
    bit_d       = bit_q;
    n_d         = n_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    dout_d      = dout_q;
    we_d        = we_q;
    sclk_d      = sclk_q;
    cs_n_d      = cs_n_q;
    mosi_d      = mosi_q;
    done_d      = 1'b0;
    len_clamped = (data_len > 6'd32) ? 6'd32 : data_len;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SHIFT;
          // Read frames load zeros behind the command so MOSI idles low in the data phase.
          tx_d    = {cmd_addr, (write_enable ? data_in : 32'h0)};
          n_d     = 7'd32 + {1'b0, len_clamped};
          we_d    = write_enable;
          rx_d    = 32'h0;
          cs_n_d  = 1'b0;
          mosi_d  = cmd_addr[31];
          sclk_d  = 1'b0;
          div_d   = '0;
          phase_d = 1'b0;
          bit_d   = 7'd0;
        end
      end
      S_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!phase_q) begin
            sclk_d  = 1'b1;
            phase_d = 1'b1;
            if (bit_q >= 7'd32) begin
              rx_d = {rx_q[30:0], spi_miso};
            end
          end else begin
            sclk_d  = 1'b0;
            phase_d = 1'b0;
            if (bit_q == n_q - 7'd1) begin
              state_d = S_IDLE;
              cs_n_d  = 1'b1;
              mosi_d  = 1'b0;
              done_d  = 1'b1;
              if (!we_q) begin
                dout_d = rx_q;
              end
            end else begin
              bit_d  = bit_q + 7'd1;
              tx_d   = {tx_q[62:0], 1'b0};
              mosi_d = tx_q[62];
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      phase_q <= 1'b0;
      bit_q   <= 7'd0;
      n_q     <= 7'd0;
      tx_q    <= 64'h0;
      rx_q    <= 32'h0;
      dout_q  <= 32'h0;
      we_q    <= 1'b0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      n_q     <= n_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      dout_q  <= dout_d;
      we_q    <= we_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      mosi_q  <= mosi_d;
      done_q  <= done_d;
    end
  end

  assign data_out = dout_q;
  assign done     = done_q;
  assign spi_clk  = sclk_q;
  assign spi_cs_n = cs_n_q;
  assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_master_core.sv
// Directed bench for spi_master_core (CLK_DIV=2): a MOSI capture monitor and a
// MISO slave stream feed checks on latency, frame shape and read data.
module tb_spi_master_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        write_enable;
  logic [31:0] cmd_addr;
  logic [5:0]  data_len;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        done;
  logic        spi_clk;
  logic        spi_cs_n;
  logic        spi_mosi;
  logic        spi_miso;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  spi_master_core #(.CLK_DIV(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .write_enable (write_enable),
    .cmd_addr     (cmd_addr),
    .data_len     (data_len),
    .data_in      (data_in),
    .data_out     (data_out),
    .done         (done),
    .spi_clk      (spi_clk),
    .spi_cs_n     (spi_cs_n),
    .spi_mosi     (spi_mosi),
    .spi_miso     (spi_miso)
  );

  // MOSI monitor: every rising spi_clk shifts the line in and counts the edge.
  logic [63:0] mosi_cap = 64'h0;
  int          rises    = 0;
  always @(posedge spi_clk) begin
    mosi_cap <= {mosi_cap[62:0], spi_mosi};
    rises    <= rises + 1;
  end

  // Slave: presents miso_stream MSB first, advancing on each falling spi_clk.
  logic [63:0] miso_stream = 64'h0;
  int          falls       = 0;
  logic        in_frame    = 1'b0;
  always @(negedge spi_cs_n or posedge spi_cs_n or negedge spi_clk) begin
    if (spi_cs_n) begin
      in_frame <= 1'b0;
    end else if (!in_frame) begin
      in_frame <= 1'b1;
      falls    <= 0;
    end else begin
      falls <= falls + 1;
    end
  end
  assign spi_miso = (in_frame && falls < 64) ? miso_stream[63 - falls] : 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic we, input logic [31:0] ca, input logic [31:0] din,
                        input logic [5:0] len);
    write_enable = we;
    cmd_addr     = ca;
    data_in      = din;
    data_len     = len;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("done_single_cycle", done, 1'b0);
  endtask

  // Counts cycles from the start-sampling edge until done; optionally pulses
  // a conflicting start at cycle mid while the frame is busy.
  task automatic wait_done(input string tag, input int exp_cyc, input int mid);
    int cyc;
    int cs_hi;
    bit seen;
    cyc   = 0;
    cs_hi = 0;
    seen  = 1'b0;
    while (!seen && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == mid) begin
        start        = 1'b1;
        cmd_addr     = 32'hFFFF_FFFF;
        data_len     = 6'd32;
        write_enable = 1'b1;
      end else if (cyc == mid + 1) begin
        start = 1'b0;
      end
      if (done) seen = 1'b1;
      else if (spi_cs_n) cs_hi++;
    end
    check({tag, "_done_seen"}, seen, 1'b1);
    check({tag, "_latency"}, cyc, exp_cyc);
    check({tag, "_cs_low_frame"}, cs_hi, 0);
    check({tag, "_cs_high_on_done"}, spi_cs_n, 1'b1);
  endtask

  initial begin
    int r0;
    rst_n        = 1'b0;
    start        = 1'b0;
    write_enable = 1'b0;
    cmd_addr     = 32'h0;
    data_len     = 6'd0;
    data_in      = 32'h0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs_n", spi_cs_n, 1'b1);
    check("rst_spi_clk", spi_clk, 1'b0);
    check("rst_mosi", spi_mosi, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_data_out", data_out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Word read; data_in must not leak onto MOSI, command-phase MISO ones are discarded
    miso_stream = {32'hFFFF_FFFF, 32'h1300_5000};
    r0 = rises;
    launch(1'b0, 32'h0300_0100, 32'hDEAD_BEEF, 6'd32);
    wait_done("word_rd", 256, -1);
    check("word_rd_data", data_out, 32'h1300_5000);
    check("word_rd_mosi", mosi_cap, {32'h0300_0100, 32'h0});
    check("word_rd_rises", rises - r0, 64);
    @(posedge clk);
    #1;
    check("word_rd_done_low", done, 1'b0);

    // Byte write
    miso_stream = 64'h5A5A_5A5A_5A5A_5A5A;
    r0 = rises;
    launch(1'b1, 32'h0200_0010, 32'hA500_0000, 6'd8);
    wait_done("byte_wr", 160, -1);
    check("byte_wr_mosi", mosi_cap[39:0], {32'h0200_0010, 8'hA5});
    check("byte_wr_rises", rises - r0, 40);
    check("byte_wr_data_kept", data_out, 32'h1300_5000);

    // Reset during the command phase
    launch(1'b0, 32'h0312_3456, 32'h0, 6'd32);
    repeat (20) @(posedge clk);
    #1;
    check("midrst_cs_before", spi_cs_n, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_cs_n", spi_cs_n, 1'b1);
    check("midrst_spi_clk", spi_clk, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_data_out", data_out, 32'h0);
    check("midrst_mosi", spi_mosi, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Halfword read after reset
    miso_stream = {32'hFFFF_FFFF, 32'hBEEF_0000};
    r0 = rises;
    launch(1'b0, 32'h0B12_3456, 32'h0, 6'd16);
    wait_done("half_rd", 192, -1);
    check("half_rd_data", data_out, 32'h0000_BEEF);
    check("half_rd_mosi", mosi_cap[47:0], {32'h0B12_3456, 16'h0});
    check("half_rd_rises", rises - r0, 48);

    // Zero-length read: command only, data_out clears
    miso_stream = 64'hFFFF_FFFF_FFFF_FFFF;
    r0 = rises;
    launch(1'b0, 32'h05AA_55AA, 32'h0, 6'd0);
    wait_done("len0", 128, -1);
    check("len0_rises", rises - r0, 32);
    check("len0_mosi", mosi_cap[31:0], 32'h05AA_55AA);
    check("len0_data", data_out, 32'h0);

    // Over-length request clamps to 32 data bits
    miso_stream = {32'hFFFF_FFFF, 32'hCAFE_F00D};
    r0 = rises;
    launch(1'b0, 32'h0300_0200, 32'h0, 6'd40);
    wait_done("clamp", 256, -1);
    check("clamp_rises", rises - r0, 64);
    check("clamp_data", data_out, 32'hCAFE_F00D);

    // Busy start ignored, then back-to-back read launched on the done cycle
    miso_stream = {32'hFFFF_FFFF, 32'h1234_0000};
    r0 = rises;
    launch(1'b1, 32'h02AB_CDEF, 32'h3C00_0000, 6'd8);
    wait_done("busy_wr", 160, 50);
    check("busy_wr_mosi", mosi_cap[39:0], {32'h02AB_CDEF, 8'h3C});
    check("busy_wr_rises", rises - r0, 40);
    r0 = rises;
    launch(1'b0, 32'h0300_0400, 32'h0, 6'd16);
    check("b2b_cs_reasserted", spi_cs_n, 1'b0);
    wait_done("b2b_rd", 192, -1);
    check("b2b_rd_data", data_out, 32'h0000_1234);
    check("b2b_rd_mosi", mosi_cap[47:0], {32'h0300_0400, 16'h0});
    check("b2b_rd_rises", rises - r0, 48);
    @(posedge clk);
    #1;
    check("b2b_done_low", done, 1'b0);
    check("b2b_idle_cs", spi_cs_n, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
